// File: rtl/serial_paralelo_param_if.sv
// Serial-to-parallel link bundle: serial bit in, aligned word and link status out.
// master: the serial source and status consumer; slave: the deserializer.
interface serial_paralelo_param_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOCK_COUNT = 4
);
  localparam int unsigned CntW = $clog2(LOCK_COUNT + 1);

  logic             data_input;
  logic             active_output;
  logic [WIDTH-1:0] data_output;
  logic             valid_output;
  logic             word_strobe;
  logic [CntW-1:0]  BC_contador;

  modport master (
    output data_input,
    input  active_output,
    input  data_output,
    input  valid_output,
    input  word_strobe,
    input  BC_contador
  );

  modport slave (
    input  data_input,
    output active_output,
    output data_output,
    output valid_output,
    output word_strobe,
    output BC_contador
  );
endinterface

// File: rtl/serial_paralelo_param.sv
// Parametrised MSB-first deserializer with comma alignment on a single bit clock.
// Hunts for COMMA at any bit offset, locks after LOCK_COUNT consecutive aligned
// commas, then delivers non-comma words with a one-cycle valid pulse.
// Optional macro SP_LOSS_DETECT_EN: drop lock after LOSS_COUNT misaligned commas.
module serial_paralelo_param #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter int unsigned      LOCK_COUNT = 4,
  parameter int unsigned      LOSS_COUNT = 2
) (
  input logic                    clk_32f,
  input logic                    reset_L,
  serial_paralelo_param_if.slave bus
);

  localparam int unsigned BitW = $clog2(WIDTH);
  localparam int unsigned CntW = $clog2(LOCK_COUNT + 1);

  localparam logic [BitW-1:0] LastBit  = BitW'(WIDTH - 1);
  localparam logic [CntW-1:0] LockVal  = CntW'(LOCK_COUNT);
  localparam logic [CntW-1:0] LockPrev = CntW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    StHunt,
    StAlign,
    StActive
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [BitW-1:0]  bit_cnt_q;
  // Bits shifted since reset, saturating; gates comma matches until sr is full.
  logic [BitW-1:0]  fill_q;
  logic [CntW-1:0]  bc_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             strobe_q;
  logic             active_q;

  logic [WIDTH-1:0] sr_next;
  logic             is_comma;
  logic             word_done;
  logic             sr_full;

`ifdef SP_LOSS_DETECT_EN
  localparam int unsigned     LossW    = $clog2(LOSS_COUNT + 1);
  localparam logic [LossW-1:0] LossPrev = LossW'(LOSS_COUNT - 1);
  logic [LossW-1:0] miss_q;
`else
  // Lock is only released by reset in this build.
  logic unused_loss_count;
  assign unused_loss_count = ^LOSS_COUNT;
`endif

  // The oldest bit falls off the shift register and is never compared.
  logic unused_sr_msb;
  assign unused_sr_msb = sr_q[WIDTH-1];

  // Next shift-register contents and the match/boundary qualifiers built on it.
  always_comb begin
    sr_next   = {sr_q[WIDTH-2:0], bus.data_input};
    is_comma  = (sr_next == COMMA);
    word_done = (bit_cnt_q == LastBit);
    sr_full   = (fill_q == LastBit);
  end

  // Alignment FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= StHunt;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      fill_q    <= '0;
      bc_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
`ifdef SP_LOSS_DETECT_EN
      miss_q    <= '0;
`endif
    end else begin
      sr_q     <= sr_next;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      if (!sr_full) begin
        fill_q <= fill_q + 1'b1;
      end

      unique case (state_q)
        StHunt: begin
          // Any bit offset is acceptable; a match defines the new word boundary.
          if (sr_full && is_comma) begin
            bit_cnt_q <= '0;
            bc_q      <= CntW'(1);
            if (LOCK_COUNT == 1) begin
              state_q  <= StActive;
              active_q <= 1'b1;
            end else begin
              state_q <= StAlign;
            end
          end
        end

        StAlign: begin
          bit_cnt_q <= word_done ? '0 : bit_cnt_q + 1'b1;
          if (word_done) begin
            strobe_q <= 1'b1;
            if (is_comma) begin
              bc_q <= bc_q + 1'b1;
              if (bc_q == LockPrev) begin
                state_q  <= StActive;
                active_q <= 1'b1;
              end
            end else begin
              state_q <= StHunt;
              bc_q    <= '0;
            end
          end
        end

        StActive: begin
          bit_cnt_q <= word_done ? '0 : bit_cnt_q + 1'b1;
          bc_q      <= LockVal;
          if (word_done) begin
            strobe_q <= 1'b1;
            // Commas are idle fill: only real data updates the word output.
            if (!is_comma) begin
              data_q  <= sr_next;
              valid_q <= 1'b1;
            end
          end
`ifdef SP_LOSS_DETECT_EN
          if (word_done) begin
            if (is_comma) begin
              miss_q <= '0;
            end
          end else if (is_comma) begin
            if (miss_q == LossPrev) begin
              state_q  <= StHunt;
              active_q <= 1'b0;
              bc_q     <= '0;
              miss_q   <= '0;
            end else begin
              miss_q <= miss_q + 1'b1;
            end
          end
`endif
        end

        default: begin
          state_q  <= StHunt;
          bc_q     <= '0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.active_output = active_q;
  assign bus.data_output   = data_q;
  assign bus.valid_output  = valid_q;
  assign bus.word_strobe   = strobe_q;
  assign bus.BC_contador   = bc_q;

endmodule

// File: tb/tb_serial_paralelo_param.sv
// Self-checking bench for serial_paralelo_param (default parameters).
// Word-level reference model: tracks aligned/active/comma count/last data per word.
module tb_serial_paralelo_param;

  localparam int unsigned W    = 8;
  localparam int unsigned LOCK = 4;
  localparam logic [7:0]  COMMA_V = 8'hBC;

  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;

  always #5 clk_32f = ~clk_32f;

  serial_paralelo_param_if #(.WIDTH(W), .LOCK_COUNT(LOCK)) bus ();

  serial_paralelo_param #(
    .WIDTH(W),
    .COMMA(COMMA_V),
    .LOCK_COUNT(LOCK),
    .LOSS_COUNT(2)
  ) dut (
    .clk_32f(clk_32f),
    .reset_L(reset_L),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_strobe = 0;

  // Reference model state.
  bit         m_aligned;
  bit         m_active;
  int         m_bc;
  logic [7:0] m_data;
  logic [7:0] prev_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 1 when {a,b} holds COMMA at a non-word-aligned offset.
  function automatic bit cc(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] cat;
    cat = {a, b};
    for (int s = 1; s < 8; s++) begin
      if (cat[15-s -: 8] == COMMA_V) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] pick(input logic [7:0] prev);
    logic [7:0] w;
    do w = 8'($urandom); while (w == COMMA_V || cc(prev, w) || cc(w, COMMA_V));
    return w;
  endfunction

  task automatic model_reset();
    m_aligned = 1'b0;
    m_active  = 1'b0;
    m_bc      = 0;
    m_data    = 8'h00;
    prev_w    = 8'h00;
  endtask

  // Word-level rules applied to one complete aligned word.
  task automatic model_word(input logic [7:0] w, output bit exp_strobe, output bit exp_valid);
    exp_strobe = m_aligned;
    exp_valid  = 1'b0;
    if (!m_aligned) begin
      if (w == COMMA_V) begin
        m_aligned = 1'b1;
        m_bc      = 1;
        if (LOCK == 1) m_active = 1'b1;
      end
    end else if (!m_active) begin
      if (w == COMMA_V) begin
        m_bc++;
        if (m_bc == LOCK) m_active = 1'b1;
      end else begin
        m_aligned = 1'b0;
        m_bc      = 0;
      end
    end else if (w != COMMA_V) begin
      m_data    = w;
      exp_valid = 1'b1;
    end
  endtask

  task automatic send_bit(input logic b);
    bus.data_input = b;
    @(posedge clk_32f);
    #1;
    if (bus.valid_output === 1'b1) n_valid++;
    if (bus.word_strobe === 1'b1) n_strobe++;
  endtask

  task automatic send_word(input logic [7:0] w);
    bit es, ev;
    for (int i = 7; i >= 1; i--) begin
      send_bit(w[i]);
      check("mid_valid", bus.valid_output, 0);
      check("mid_strobe", bus.word_strobe, 0);
      check("mid_active", bus.active_output, m_active);
    end
    send_bit(w[0]);
    model_word(w, es, ev);
    check("strobe", bus.word_strobe, es);
    check("valid", bus.valid_output, ev);
    check("active", bus.active_output, m_active);
    check("bc", bus.BC_contador, m_bc);
    check("data", bus.data_output, m_data);
    prev_w = w;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    bus.data_input = 1'b0;
    @(posedge clk_32f);
    @(posedge clk_32f);
    #1;
    reset_L = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [7:0] c;
    logic [7:0] w;
    int         v0, s0, k;
    c = COMMA_V;

    // Reset state.
    do_reset();
    check("rst_active", bus.active_output, 0);
    check("rst_valid", bus.valid_output, 0);
    check("rst_strobe", bus.word_strobe, 0);
    check("rst_bc", bus.BC_contador, 0);
    check("rst_data", bus.data_output, 0);

    // Aligned lock: count steps 1..4, active after bit 32.
    for (int i = 0; i < 4; i++) send_word(COMMA_V);
    check("lock_active", bus.active_output, 1);

    // Random data with interleaved idle commas.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) send_word(COMMA_V);
      else send_word(pick(prev_w));
    end

    // Commas are idle: two valid pulses, four strobes.
    send_word(COMMA_V);
    v0 = n_valid;
    s0 = n_strobe;
    send_word(COMMA_V);
    send_word(8'h3C);
    send_word(COMMA_V);
    send_word(8'hF0);
    check("idle_valid_cnt", n_valid - v0, 2);
    check("idle_strobe_cnt", n_strobe - s0, 4);
    check("idle_data", bus.data_output, 8'hF0);

    // Asynchronous reset mid-word clears everything before the next edge.
    send_word(COMMA_V);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #2 reset_L = 1'b0;
    #1;
    check("async_active", bus.active_output, 0);
    check("async_bc", bus.BC_contador, 0);
    check("async_data", bus.data_output, 0);
    check("async_valid", bus.valid_output, 0);
    check("async_strobe", bus.word_strobe, 0);
    @(posedge clk_32f);
    #1 reset_L = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) send_word(COMMA_V);
    check("relock_not_yet", bus.active_output, 0);
    send_word(COMMA_V);
    check("relock_active", bus.active_output, 1);

    // One-bit slip: commas seen misaligned twice.
    send_word(COMMA_V);
    send_bit(1'b0);
    for (int i = 7; i >= 1; i--) send_bit(c[i]);
    check("slip_valid1", bus.valid_output, 1);
    check("slip_data1", bus.data_output, {1'b0, c[7:1]});
    send_bit(c[0]);
    check("slip_det1_active", bus.active_output, 1);
    for (int i = 7; i >= 1; i--) send_bit(c[i]);
    check("slip_valid2", bus.valid_output, 1);
    check("slip_data2", bus.data_output, {c[0], c[7:1]});
    check("slip_pre2_active", bus.active_output, 1);
    send_bit(c[0]);
`ifdef SP_LOSS_DETECT_EN
    check("loss_active", bus.active_output, 0);
    check("loss_bc", bus.BC_contador, 0);
`else
    check("noloss_active", bus.active_output, 1);
    check("noloss_bc", bus.BC_contador, LOCK);
`endif

    // Three commas then data drops back to hunt with no valid pulse.
    do_reset();
    for (int i = 0; i < 3; i++) send_word(COMMA_V);
    send_word(8'h55);
    check("break_bc", bus.BC_contador, 0);
    check("break_valid", bus.valid_output, 0);
    check("break_active", bus.active_output, 0);

    // Lock at bit offset 3 after junk 101, then one data word.
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    v0 = n_valid;
    for (int i = 0; i < 4; i++) send_word(COMMA_V);
    check("off3_active", bus.active_output, 1);
    send_word(8'hA5);
    check("off3_data", bus.data_output, 8'hA5);
    check("off3_valid_cnt", n_valid - v0, 1);

    // Random offset of leading zeros, then lock and a random word.
    do_reset();
    k = $urandom_range(1, 7);
    for (int i = 0; i < k; i++) send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_word(COMMA_V);
    w = pick(COMMA_V);
    send_word(w);
    check("rndoff_data", bus.data_output, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
